audio_dc_blocker: RTL and testbench

- Stereo first-order DC-blocking high-pass stage that consumes `dc_ce`, `dc_sample_rate` and `dc_mute` from the audio filter control block.
- Sits downstream of the IIR low-pass and feeds the final audio output / DAC serialiser.
- Processes both channels with one shared datapath, time-multiplexed left then right.
- Held-mute start-up behaviour and saturated 16-bit output.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/dc_blocker_core.sv | 44 ++++
 rtl/audio_dc_blocker.sv | 113 +++++++++++
 tb/tb_audio_dc_blocker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the stereo DC-blocking high-pass stage.
package audio_pkg;

  localparam int unsigned DEF_IN_W = 16;
  localparam int unsigned DEF_FRAC = 16;
  localparam int unsigned DEF_K_LO = 10;
  localparam int unsigned DEF_K_HI = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_L = 2'd1,
    CALC_R = 2'd2,
    DONE   = 2'd3
  } dc_state_e;

  // Feedback state width: sample width plus fraction plus two guard bits.
  function automatic int unsigned state_w(input int unsigned in_w, input int unsigned frac);
    return in_w + frac + 2;
  endfunction

endpackage

// File: rtl/dc_blocker_core.sv
// One-channel DC-blocker update: next feedback state and saturated output sample.
module dc_blocker_core
  import audio_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W,
  parameter int unsigned FRAC = DEF_FRAC,
  parameter int unsigned K_LO = DEF_K_LO,
  parameter int unsigned K_HI = DEF_K_HI
) (
  input  logic signed [IN_W-1:0]              x,
  input  logic signed [IN_W-1:0]              x_prev,
  input  logic signed [IN_W+FRAC+1:0]         y,
  input  logic                                k_hi,
  input  logic                                mute,
  output logic signed [IN_W+FRAC+1:0]         y_next_c,
  output logic signed [IN_W-1:0]              out_c
);

  localparam int unsigned SW = state_w(IN_W, FRAC);

  logic signed [IN_W:0]   diff;
  logic signed [SW-1:0]   diff_sh;
  logic signed [SW-1:0]   leak;
  logic signed [SW-1:0]   sum;
  logic signed [IN_W+1:0] q;
  logic                   ovf;
  logic signed [IN_W-1:0] sat;

  assign diff    = {x[IN_W-1], x} - {x_prev[IN_W-1], x_prev};
  assign diff_sh = {diff[IN_W], diff, {FRAC{1'b0}}};
  assign leak    = k_hi ? (y >>> K_HI) : (y >>> K_LO);
  assign sum     = y + diff_sh - leak;

  // Dropping the fraction bits is an arithmetic shift, i.e. floor toward -inf.
  assign q   = sum[SW-1:FRAC];
  assign ovf = ~(&q[IN_W+1:IN_W-1]) & (|q[IN_W+1:IN_W-1]);
  assign sat = ovf ? (q[IN_W+1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}})
                   : q[IN_W-1:0];

  // Muting zeroes the state so unmuting resumes from the input difference alone.
  assign y_next_c = mute ? '0 : sum;
  assign out_c    = mute ? '0 : sat;

endmodule

// File: rtl/audio_dc_blocker.sv
// Stereo DC-blocking high-pass; one shared datapath runs left then right per sample pair.
module audio_dc_blocker
  import audio_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W,
  parameter int unsigned FRAC = DEF_FRAC,
  parameter int unsigned K_LO = DEF_K_LO,
  parameter int unsigned K_HI = DEF_K_HI
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   sample_rate,
  input  logic                   mute,
  input  logic signed [IN_W-1:0] in_l,
  input  logic signed [IN_W-1:0] in_r,
  output logic signed [IN_W-1:0] out_l,
  output logic signed [IN_W-1:0] out_r,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int unsigned SW = state_w(IN_W, FRAC);

  dc_state_e state;

  logic signed [IN_W-1:0] x_l, x_r;
  logic signed [IN_W-1:0] x_prev_l, x_prev_r;
  logic signed [IN_W-1:0] res_l, res_r;
  logic signed [SW-1:0]   y_l, y_r;
  logic                   k_hi;
  logic                   muted;

  logic                   sel_r;
  logic signed [IN_W-1:0] core_x, core_xp, core_out;
  logic signed [SW-1:0]   core_y, core_y_next;

  // Operand muxes steer the shared core to the channel being computed.
  assign sel_r   = (state == CALC_R);
  assign core_x  = sel_r ? x_r      : x_l;
  assign core_xp = sel_r ? x_prev_r : x_prev_l;
  assign core_y  = sel_r ? y_r      : y_l;

  dc_blocker_core #(
    .IN_W (IN_W),
    .FRAC (FRAC),
    .K_LO (K_LO),
    .K_HI (K_HI)
  ) u_core (
    .x        (core_x),
    .x_prev   (core_xp),
    .y        (core_y),
    .k_hi     (k_hi),
    .mute     (muted),
    .y_next_c (core_y_next),
    .out_c    (core_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_l       <= '0;
      x_r       <= '0;
      x_prev_l  <= '0;
      x_prev_r  <= '0;
      res_l     <= '0;
      res_r     <= '0;
      y_l       <= '0;
      y_r       <= '0;
      k_hi      <= 1'b0;
      muted     <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ce) begin
            x_l   <= in_l;
            x_r   <= in_r;
            k_hi  <= sample_rate;
            muted <= mute;
            busy  <= 1'b1;
            state <= CALC_L;
          end
        end
        CALC_L: begin
          y_l      <= core_y_next;
          x_prev_l <= x_l;
          res_l    <= core_out;
          state    <= CALC_R;
        end
        CALC_R: begin
          y_r      <= core_y_next;
          x_prev_r <= x_r;
          res_r    <= core_out;
          state    <= DONE;
        end
        DONE: begin
          out_l     <= res_l;
          out_r     <= res_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dc_blocker.sv
// Self-checking bench for audio_dc_blocker: vector table, directed corners, random vs. model.
module tb_audio_dc_blocker;

  localparam int K_LO = 10;
  localparam int K_HI = 9;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce = 1'b0;
  logic               sample_rate = 1'b0;
  logic               mute = 1'b0;
  logic signed [15:0] in_l = '0;
  logic signed [15:0] in_r = '0;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               out_valid;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Reference state: unbounded integers, floor shifts, clamp at the output.
  longint my_l, my_r;
  int     mxp_l, mxp_r;

  typedef struct {
    int l;
    int r;
    bit sr;
    bit m;
    int exp_l;
    int exp_r;
  } vec_t;

  vec_t vecs [7];

  audio_dc_blocker dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .sample_rate (sample_rate),
    .mute        (mute),
    .in_l        (in_l),
    .in_r        (in_r),
    .out_l       (out_l),
    .out_r       (out_r),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input int act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0d outside allowed range", name, act);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_chan(input int x, input bit m, input int k,
                            inout longint y, inout int xp, output int o);
    if (m) begin
      y = 0;
      o = 0;
    end else begin
      y = y + (longint'(x - xp) <<< 16) - (y >>> k);
      o = clamp16(y >>> 16);
    end
    xp = x;
  endtask

  task automatic model_reset();
    my_l = 0; my_r = 0; mxp_l = 0; mxp_r = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One accepted sample pair: drive ce, await out_valid, compare against the model.
  task automatic apply(input int l, input int r, input bit sr, input bit m,
                       output int ol, output int orr);
    int el, er, lat;
    bit got;
    in_l = 16'(l); in_r = 16'(r); sample_rate = sr; mute = m; ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    got = 1'b0; lat = 0;
    for (int n = 1; n <= 10 && !got; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1'b1; lat = n; end
    end
    model_chan(l, m, sr ? K_HI : K_LO, my_l, mxp_l, el);
    model_chan(r, m, sr ? K_HI : K_LO, my_r, mxp_r, er);
    if (!got) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout actual none required pulse");
      ol = 0; orr = 0;
    end else begin
      check("latency", lat, 3);
      ol = int'(out_l); orr = int'(out_r);
      check("model_l", ol, el);
      check("model_r", orr, er);
    end
  endtask

  task automatic watch(input int cycles, output int pulses, output int busy_seen);
    pulses = 0; busy_seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
      if (busy) busy_seen++;
    end
  endtask

  initial begin
    int ol, orr, pulses, bsy, cap_l, cap_r, el, er, l, r;

    vecs[0] = '{l: -32768, r: 0,    sr: 1'b0, m: 1'b0, exp_l: -32768, exp_r: 0};
    vecs[1] = '{l:  32767, r: 0,    sr: 1'b0, m: 1'b0, exp_l:  32767, exp_r: 0};
    vecs[2] = '{l:  32767, r: 0,    sr: 1'b0, m: 1'b0, exp_l:  32766, exp_r: 0};
    vecs[3] = '{l:  32767, r: 0,    sr: 1'b0, m: 1'b0, exp_l:  32734, exp_r: 0};
    vecs[4] = '{l: -32768, r: 100,  sr: 1'b0, m: 1'b1, exp_l:  0,     exp_r: 0};
    vecs[5] = '{l: -32768, r: 100,  sr: 1'b0, m: 1'b0, exp_l:  0,     exp_r: 0};
    vecs[6] = '{l:  0,     r: -100, sr: 1'b1, m: 1'b0, exp_l:  32767, exp_r: -200};

    do_reset();

    // Idle after reset.
    watch(20, pulses, bsy);
    check("idle_valid", pulses, 0);
    check("idle_busy", bsy, 0);
    check("idle_out_l", int'(out_l), 0);
    check("idle_out_r", int'(out_r), 0);

    // Saturation, decay without wrap, mute and sample-rate vectors.
    foreach (vecs[i]) begin
      apply(vecs[i].l, vecs[i].r, vecs[i].sr, vecs[i].m, ol, orr);
      check($sformatf("vec%0d_l", i), ol, vecs[i].exp_l);
      check($sformatf("vec%0d_r", i), orr, vecs[i].exp_r);
    end

    // Step response, slow leak.
    do_reset();
    for (int i = 1; i <= 8000; i++) begin
      apply(1000, 1000, 1'b0, 1'b0, ol, orr);
      if (i == 1) begin
        check("step_first_l", ol, 1000);
        check("step_first_r", orr, 1000);
      end
      if (i == 710) begin
        check_cond("half_life_lo_l", ol >= 498 && ol <= 502, ol);
        check_cond("half_life_lo_r", orr >= 498 && orr <= 502, orr);
      end
      if (i == 8000) begin
        check_cond("settled_l", ol >= -1 && ol <= 1, ol);
        check_cond("settled_r", orr >= -1 && orr <= 1, orr);
      end
    end

    // Step response, fast leak.
    do_reset();
    for (int i = 1; i <= 355; i++) begin
      apply(1000, 1000, 1'b1, 1'b0, ol, orr);
      if (i == 355) begin
        check_cond("half_life_hi_l", ol >= 498 && ol <= 502, ol);
        check_cond("half_life_hi_r", orr >= 498 && orr <= 502, orr);
      end
    end

    // Held mute then release with constant input.
    for (int i = 0; i < 20; i++) begin
      apply(5000, 5000, 1'b0, 1'b1, ol, orr);
      check("muted_l", ol, 0);
      check("muted_r", orr, 0);
    end
    apply(5000, 5000, 1'b0, 1'b0, ol, orr);
    check("unmute_l", ol, 0);
    check("unmute_r", orr, 0);

    // Overrun: second ce two cycles after the first is dropped.
    in_l = 16'(1234); in_r = -16'sd777; sample_rate = 1'b0; mute = 1'b0; ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    @(posedge clk); #1;
    in_l = 16'(9999); in_r = 16'(9999); ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    pulses = 0; cap_l = 0; cap_r = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin pulses++; cap_l = int'(out_l); cap_r = int'(out_r); end
    end
    check("overrun_pulses", pulses, 1);
    model_chan(1234, 1'b0, K_LO, my_l, mxp_l, el);
    model_chan(-777, 1'b0, K_LO, my_r, mxp_r, er);
    check("overrun_l", cap_l, el);
    check("overrun_r", cap_r, er);
    apply(1234, -777, 1'b0, 1'b0, ol, orr);

    // Reset one cycle after ce aborts the pair and clears state.
    in_l = 16'(3000); in_r = 16'(3000); ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    watch(8, pulses, bsy);
    check("abort_pulses", pulses, 0);
    check("abort_busy", bsy, 0);
    check("abort_out_l", int'(out_l), 0);
    check("abort_out_r", int'(out_r), 0);
    apply(100, -100, 1'b0, 1'b0, ol, orr);
    check("post_abort_l", ol, 100);
    check("post_abort_r", orr, -100);

    // ce coincident with reset: reset wins.
    in_l = 16'(4000); in_r = 16'(4000); ce = 1'b1; reset = 1'b1;
    @(posedge clk); #1 ce = 1'b0; reset = 1'b0;
    model_reset();
    watch(6, pulses, bsy);
    check("ce_reset_pulses", pulses, 0);
    apply(50, 50, 1'b0, 1'b0, ol, orr);
    check("post_ce_reset_l", ol, 50);
    check("post_ce_reset_r", orr, 50);

    // Random traffic against the model, including extremes and idle gaps.
    for (int i = 0; i < 400; i++) begin
      l = int'($urandom_range(0, 65535)) - 32768;
      r = int'($urandom_range(0, 65535)) - 32768;
      if (i % 37 == 0) l = (i % 2 == 0) ? 32767 : -32768;
      if (i % 41 == 0) r = (i % 2 == 0) ? -32768 : 32767;
      apply(l, r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ol, orr);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
